// File: rtl/output_selecter_transpose.sv
// rtl/output_selecter_transpose.sv - two-pass transpose/scale feedback and output stage for the 4x4 2D FFT
// Sequences row pass then column pass; owns the input-selector pass select.
module output_selecter_transpose #(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     fft_valid,
  input  logic signed [DATA_W-1:0] fft_1_1_r, fft_1_1_i, fft_1_2_r, fft_1_2_i, fft_1_3_r, fft_1_3_i, fft_1_4_r, fft_1_4_i,
  input  logic signed [DATA_W-1:0] fft_2_1_r, fft_2_1_i, fft_2_2_r, fft_2_2_i, fft_2_3_r, fft_2_3_i, fft_2_4_r, fft_2_4_i,
  input  logic signed [DATA_W-1:0] fft_3_1_r, fft_3_1_i, fft_3_2_r, fft_3_2_i, fft_3_3_r, fft_3_3_i, fft_3_4_r, fft_3_4_i,
  input  logic signed [DATA_W-1:0] fft_4_1_r, fft_4_1_i, fft_4_2_r, fft_4_2_i, fft_4_3_r, fft_4_3_i, fft_4_4_r, fft_4_4_i,
  output logic                     sel,
  output logic signed [DATA_W-1:0] rt_1_1_r, rt_1_1_i, rt_1_2_r, rt_1_2_i, rt_1_3_r, rt_1_3_i, rt_1_4_r, rt_1_4_i,
  output logic signed [DATA_W-1:0] rt_2_1_r, rt_2_1_i, rt_2_2_r, rt_2_2_i, rt_2_3_r, rt_2_3_i, rt_2_4_r, rt_2_4_i,
  output logic signed [DATA_W-1:0] rt_3_1_r, rt_3_1_i, rt_3_2_r, rt_3_2_i, rt_3_3_r, rt_3_3_i, rt_3_4_r, rt_3_4_i,
  output logic signed [DATA_W-1:0] rt_4_1_r, rt_4_1_i, rt_4_2_r, rt_4_2_i, rt_4_3_r, rt_4_3_i, rt_4_4_r, rt_4_4_i,
  output logic signed [DATA_W-1:0] out_1_1_r, out_1_1_i, out_1_2_r, out_1_2_i, out_1_3_r, out_1_3_i, out_1_4_r, out_1_4_i,
  output logic signed [DATA_W-1:0] out_2_1_r, out_2_1_i, out_2_2_r, out_2_2_i, out_2_3_r, out_2_3_i, out_2_4_r, out_2_4_i,
  output logic signed [DATA_W-1:0] out_3_1_r, out_3_1_i, out_3_2_r, out_3_2_i, out_3_3_r, out_3_3_i, out_3_4_r, out_3_4_i,
  output logic signed [DATA_W-1:0] out_4_1_r, out_4_1_i, out_4_2_r, out_4_2_i, out_4_3_r, out_4_3_i, out_4_4_r, out_4_4_i,
  output logic                     out_valid,
  output logic                     busy,
  output logic [7:0]               frame_cnt
);

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2} state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d, busy_q, busy_d, out_valid_q, out_valid_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       cap_rt, cap_out;

  smp_t fft_r [4][4];
  smp_t fft_i [4][4];
  smp_t rt_r_q [4][4];
  smp_t rt_i_q [4][4];
  smp_t out_r_q [4][4];
  smp_t out_i_q [4][4];
  smp_t rt_r_d [4][4];
  smp_t rt_i_d [4][4];
  smp_t out_r_d [4][4];
  smp_t out_i_d [4][4];

  assign fft_r[0][0] = fft_1_1_r; assign fft_r[0][1] = fft_1_2_r; assign fft_r[0][2] = fft_1_3_r; assign fft_r[0][3] = fft_1_4_r;
  assign fft_r[1][0] = fft_2_1_r; assign fft_r[1][1] = fft_2_2_r; assign fft_r[1][2] = fft_2_3_r; assign fft_r[1][3] = fft_2_4_r;
  assign fft_r[2][0] = fft_3_1_r; assign fft_r[2][1] = fft_3_2_r; assign fft_r[2][2] = fft_3_3_r; assign fft_r[2][3] = fft_3_4_r;
  assign fft_r[3][0] = fft_4_1_r; assign fft_r[3][1] = fft_4_2_r; assign fft_r[3][2] = fft_4_3_r; assign fft_r[3][3] = fft_4_4_r;
  assign fft_i[0][0] = fft_1_1_i; assign fft_i[0][1] = fft_1_2_i; assign fft_i[0][2] = fft_1_3_i; assign fft_i[0][3] = fft_1_4_i;
  assign fft_i[1][0] = fft_2_1_i; assign fft_i[1][1] = fft_2_2_i; assign fft_i[1][2] = fft_2_3_i; assign fft_i[1][3] = fft_2_4_i;
  assign fft_i[2][0] = fft_3_1_i; assign fft_i[2][1] = fft_3_2_i; assign fft_i[2][2] = fft_3_3_i; assign fft_i[2][3] = fft_3_4_i;
  assign fft_i[3][0] = fft_4_1_i; assign fft_i[3][1] = fft_4_2_i; assign fft_i[3][2] = fft_4_3_i; assign fft_i[3][3] = fft_4_4_i;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    cap_rt      = 1'b0;
    cap_out     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PASS1;
          busy_d  = 1'b1;
          sel_d   = 1'b0;
        end
      end
      PASS1: begin
        if (fft_valid) begin
          cap_rt  = 1'b1;
          state_d = PASS2;
          sel_d   = 1'b1;
        end
      end
      PASS2: begin
        if (fft_valid) begin
          cap_out     = 1'b1;
          out_valid_d = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = IDLE;
          sel_d       = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Both captures transpose (row R takes column R of the core result) and compensate the 4-point gain.
  always_comb begin
    rt_r_d  = rt_r_q;
    rt_i_d  = rt_i_q;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (cap_rt) begin
          rt_r_d[r][c] = fft_r[c][r] >>> SHIFT;
          rt_i_d[r][c] = fft_i[c][r] >>> SHIFT;
        end
        if (cap_out) begin
          out_r_d[r][c] = fft_r[c][r] >>> SHIFT;
          out_i_d[r][c] = fft_i[c][r] >>> SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      rt_r_q      <= '{default: '0};
      rt_i_q      <= '{default: '0};
      out_r_q     <= '{default: '0};
      out_i_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      rt_r_q      <= rt_r_d;
      rt_i_q      <= rt_i_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

  assign rt_1_1_r = rt_r_q[0][0]; assign rt_1_2_r = rt_r_q[0][1]; assign rt_1_3_r = rt_r_q[0][2]; assign rt_1_4_r = rt_r_q[0][3];
  assign rt_2_1_r = rt_r_q[1][0]; assign rt_2_2_r = rt_r_q[1][1]; assign rt_2_3_r = rt_r_q[1][2]; assign rt_2_4_r = rt_r_q[1][3];
  assign rt_3_1_r = rt_r_q[2][0]; assign rt_3_2_r = rt_r_q[2][1]; assign rt_3_3_r = rt_r_q[2][2]; assign rt_3_4_r = rt_r_q[2][3];
  assign rt_4_1_r = rt_r_q[3][0]; assign rt_4_2_r = rt_r_q[3][1]; assign rt_4_3_r = rt_r_q[3][2]; assign rt_4_4_r = rt_r_q[3][3];
  assign rt_1_1_i = rt_i_q[0][0]; assign rt_1_2_i = rt_i_q[0][1]; assign rt_1_3_i = rt_i_q[0][2]; assign rt_1_4_i = rt_i_q[0][3];
  assign rt_2_1_i = rt_i_q[1][0]; assign rt_2_2_i = rt_i_q[1][1]; assign rt_2_3_i = rt_i_q[1][2]; assign rt_2_4_i = rt_i_q[1][3];
  assign rt_3_1_i = rt_i_q[2][0]; assign rt_3_2_i = rt_i_q[2][1]; assign rt_3_3_i = rt_i_q[2][2]; assign rt_3_4_i = rt_i_q[2][3];
  assign rt_4_1_i = rt_i_q[3][0]; assign rt_4_2_i = rt_i_q[3][1]; assign rt_4_3_i = rt_i_q[3][2]; assign rt_4_4_i = rt_i_q[3][3];

  assign out_1_1_r = out_r_q[0][0]; assign out_1_2_r = out_r_q[0][1]; assign out_1_3_r = out_r_q[0][2]; assign out_1_4_r = out_r_q[0][3];
  assign out_2_1_r = out_r_q[1][0]; assign out_2_2_r = out_r_q[1][1]; assign out_2_3_r = out_r_q[1][2]; assign out_2_4_r = out_r_q[1][3];
  assign out_3_1_r = out_r_q[2][0]; assign out_3_2_r = out_r_q[2][1]; assign out_3_3_r = out_r_q[2][2]; assign out_3_4_r = out_r_q[2][3];
  assign out_4_1_r = out_r_q[3][0]; assign out_4_2_r = out_r_q[3][1]; assign out_4_3_r = out_r_q[3][2]; assign out_4_4_r = out_r_q[3][3];
  assign out_1_1_i = out_i_q[0][0]; assign out_1_2_i = out_i_q[0][1]; assign out_1_3_i = out_i_q[0][2]; assign out_1_4_i = out_i_q[0][3];
  assign out_2_1_i = out_i_q[1][0]; assign out_2_2_i = out_i_q[1][1]; assign out_2_3_i = out_i_q[1][2]; assign out_2_4_i = out_i_q[1][3];
  assign out_3_1_i = out_i_q[2][0]; assign out_3_2_i = out_i_q[2][1]; assign out_3_3_i = out_i_q[2][2]; assign out_3_4_i = out_i_q[2][3];
  assign out_4_1_i = out_i_q[3][0]; assign out_4_2_i = out_i_q[3][1]; assign out_4_3_i = out_i_q[3][2]; assign out_4_4_i = out_i_q[3][3];

endmodule

// File: tb/tb_output_selecter_transpose.sv
// tb/tb_output_selecter_transpose.sv - directed bench with a frame-level reference model
module tb_output_selecter_transpose;
  localparam int DW = 16;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic rst_n, start, fft_valid;
  logic signed [DW-1:0] f_r [4][4];
  logic signed [DW-1:0] f_i [4][4];
  logic signed [DW-1:0] rt_r [4][4];
  logic signed [DW-1:0] rt_i [4][4];
  logic signed [DW-1:0] o_r [4][4];
  logic signed [DW-1:0] o_i [4][4];
  logic sel, out_valid, busy;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  output_selecter_transpose #(.DATA_W(DW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fft_valid(fft_valid),
    .fft_1_1_r(f_r[0][0]), .fft_1_1_i(f_i[0][0]), .fft_1_2_r(f_r[0][1]), .fft_1_2_i(f_i[0][1]), .fft_1_3_r(f_r[0][2]), .fft_1_3_i(f_i[0][2]), .fft_1_4_r(f_r[0][3]), .fft_1_4_i(f_i[0][3]),
    .fft_2_1_r(f_r[1][0]), .fft_2_1_i(f_i[1][0]), .fft_2_2_r(f_r[1][1]), .fft_2_2_i(f_i[1][1]), .fft_2_3_r(f_r[1][2]), .fft_2_3_i(f_i[1][2]), .fft_2_4_r(f_r[1][3]), .fft_2_4_i(f_i[1][3]),
    .fft_3_1_r(f_r[2][0]), .fft_3_1_i(f_i[2][0]), .fft_3_2_r(f_r[2][1]), .fft_3_2_i(f_i[2][1]), .fft_3_3_r(f_r[2][2]), .fft_3_3_i(f_i[2][2]), .fft_3_4_r(f_r[2][3]), .fft_3_4_i(f_i[2][3]),
    .fft_4_1_r(f_r[3][0]), .fft_4_1_i(f_i[3][0]), .fft_4_2_r(f_r[3][1]), .fft_4_2_i(f_i[3][1]), .fft_4_3_r(f_r[3][2]), .fft_4_3_i(f_i[3][2]), .fft_4_4_r(f_r[3][3]), .fft_4_4_i(f_i[3][3]),
    .sel(sel),
    .rt_1_1_r(rt_r[0][0]), .rt_1_1_i(rt_i[0][0]), .rt_1_2_r(rt_r[0][1]), .rt_1_2_i(rt_i[0][1]), .rt_1_3_r(rt_r[0][2]), .rt_1_3_i(rt_i[0][2]), .rt_1_4_r(rt_r[0][3]), .rt_1_4_i(rt_i[0][3]),
    .rt_2_1_r(rt_r[1][0]), .rt_2_1_i(rt_i[1][0]), .rt_2_2_r(rt_r[1][1]), .rt_2_2_i(rt_i[1][1]), .rt_2_3_r(rt_r[1][2]), .rt_2_3_i(rt_i[1][2]), .rt_2_4_r(rt_r[1][3]), .rt_2_4_i(rt_i[1][3]),
    .rt_3_1_r(rt_r[2][0]), .rt_3_1_i(rt_i[2][0]), .rt_3_2_r(rt_r[2][1]), .rt_3_2_i(rt_i[2][1]), .rt_3_3_r(rt_r[2][2]), .rt_3_3_i(rt_i[2][2]), .rt_3_4_r(rt_r[2][3]), .rt_3_4_i(rt_i[2][3]),
    .rt_4_1_r(rt_r[3][0]), .rt_4_1_i(rt_i[3][0]), .rt_4_2_r(rt_r[3][1]), .rt_4_2_i(rt_i[3][1]), .rt_4_3_r(rt_r[3][2]), .rt_4_3_i(rt_i[3][2]), .rt_4_4_r(rt_r[3][3]), .rt_4_4_i(rt_i[3][3]),
    .out_1_1_r(o_r[0][0]), .out_1_1_i(o_i[0][0]), .out_1_2_r(o_r[0][1]), .out_1_2_i(o_i[0][1]), .out_1_3_r(o_r[0][2]), .out_1_3_i(o_i[0][2]), .out_1_4_r(o_r[0][3]), .out_1_4_i(o_i[0][3]),
    .out_2_1_r(o_r[1][0]), .out_2_1_i(o_i[1][0]), .out_2_2_r(o_r[1][1]), .out_2_2_i(o_i[1][1]), .out_2_3_r(o_r[1][2]), .out_2_3_i(o_i[1][2]), .out_2_4_r(o_r[1][3]), .out_2_4_i(o_i[1][3]),
    .out_3_1_r(o_r[2][0]), .out_3_1_i(o_i[2][0]), .out_3_2_r(o_r[2][1]), .out_3_2_i(o_i[2][1]), .out_3_3_r(o_r[2][2]), .out_3_3_i(o_i[2][2]), .out_3_4_r(o_r[2][3]), .out_3_4_i(o_i[2][3]),
    .out_4_1_r(o_r[3][0]), .out_4_1_i(o_i[3][0]), .out_4_2_r(o_r[3][1]), .out_4_2_i(o_i[3][1]), .out_4_3_r(o_r[3][2]), .out_4_3_i(o_i[3][2]), .out_4_4_r(o_r[3][3]), .out_4_4_i(o_i[3][3]),
    .out_valid(out_valid), .busy(busy), .frame_cnt(frame_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_ov = 0;

  // Reference: frame phase 0 = waiting for start, 1 = awaiting row result, 2 = awaiting column result.
  int m_phase, m_cnt, m_ov;
  int m_rt_r [4][4];
  int m_rt_i [4][4];
  int m_o_r [4][4];
  int m_o_i [4][4];

  function automatic int scale(input int v);
    int d;
    d = 1 << SH;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_ov = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m_rt_r[r][c] = 0; m_rt_i[r][c] = 0; m_o_r[r][c] = 0; m_o_i[r][c] = 0;
      end
  endtask

  task automatic model_step();
    m_ov = 0;
    if (m_phase == 0) begin
      if (start) m_phase = 1;
    end else if (fft_valid) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (m_phase == 1) begin
            m_rt_r[r][c] = scale(int'(f_r[c][r])); m_rt_i[r][c] = scale(int'(f_i[c][r]));
          end else begin
            m_o_r[r][c] = scale(int'(f_r[c][r])); m_o_i[r][c] = scale(int'(f_i[c][r]));
          end
        end
      if (m_phase == 2) begin
        m_ov = 1;
        m_cnt = (m_cnt + 1) % 256;
        m_phase = 0;
      end else begin
        m_phase = 2;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("sel", int'(sel), (m_phase == 2) ? 1 : 0);
    check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    check("out_valid", int'(out_valid), m_ov);
    check("frame_cnt", int'(frame_cnt), m_cnt);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        check($sformatf("rt_%0d_%0d_r", r + 1, c + 1), int'(rt_r[r][c]), m_rt_r[r][c]);
        check($sformatf("rt_%0d_%0d_i", r + 1, c + 1), int'(rt_i[r][c]), m_rt_i[r][c]);
        check($sformatf("out_%0d_%0d_r", r + 1, c + 1), int'(o_r[r][c]), m_o_r[r][c]);
        check($sformatf("out_%0d_%0d_i", r + 1, c + 1), int'(o_i[r][c]), m_o_i[r][c]);
      end
    if (out_valid) n_ov++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        f_r[r][c] = DW'($urandom);
        f_i[r][c] = DW'($urandom);
      end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fft_valid = 1'b0;
    fill_random();
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // fft_valid while idle must not capture
    fft_valid = 1'b1; tick();
    // start together with fft_valid: start wins, no capture
    start = 1'b1; fill_random(); tick();
    check("rt_1_1_r after start+valid", int'(rt_r[0][0]), 0);
    check("busy after start", int'(busy), 1);
    // start while in PASS1 ignored
    fft_valid = 1'b0; tick();
    start = 1'b0;

    fill_random();
    f_r[0][1] = 16'sd100; f_r[1][0] = -16'sd7;
    fft_valid = 1'b1; tick();
    fft_valid = 1'b0;
    check("rt_2_1_r literal", int'(rt_r[1][0]), 25);
    check("rt_1_2_r literal", int'(rt_r[0][1]), -2);
    check("sel after pass1", int'(sel), 1);
    start = 1'b1; tick(); start = 1'b0;

    fill_random();
    f_r[2][3] = -16'sd1000; f_i[1][1] = 16'sd3;
    fft_valid = 1'b1; tick();
    fft_valid = 1'b0;
    check("out_valid literal", int'(out_valid), 1);
    check("frame_cnt literal", int'(frame_cnt), 1);
    check("out_4_3_r literal", int'(o_r[3][2]), -250);
    check("out_2_2_i literal", int'(o_i[1][1]), 0);
    check("busy end literal", int'(busy), 0);
    tick();
    check("out_valid one cycle", int'(out_valid), 0);

    // fft_valid held high across both passes
    start = 1'b1; tick(); start = 1'b0;
    fft_valid = 1'b1; fill_random(); tick();
    fill_random(); tick();
    fft_valid = 1'b0; tick(); tick();

    // asynchronous reset in the middle of PASS2
    start = 1'b1; tick(); start = 1'b0;
    fft_valid = 1'b1; fill_random(); tick(); fft_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("async sel", int'(sel), 0);
    check("async busy", int'(busy), 0);
    check("async out_valid", int'(out_valid), 0);
    check("async frame_cnt", int'(frame_cnt), 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        check("async rt_r", int'(rt_r[r][c]), 0);
        check("async rt_i", int'(rt_i[r][c]), 0);
        check("async out_r", int'(o_r[r][c]), 0);
        check("async out_i", int'(o_i[r][c]), 0);
      end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 256 back-to-back frames, each start landing in the previous out_valid cycle
    n_ov = 0;
    for (int f = 0; f < 256; f++) begin
      start = 1'b1; fft_valid = 1'b0; tick();
      start = 1'b0; fft_valid = 1'b1; fill_random(); tick();
      fill_random(); tick();
    end
    start = 1'b0; fft_valid = 1'b0;
    check("wrap frame_cnt", int'(frame_cnt), 0);
    check("wrap out_valid count", n_ov, 256);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
